arm_control_unit: RTL and testbench
===================================

Name: arm_control_unit

Overview:
- Control unit that sequences the single-cycle ARM datapath.
- Decodes cond/op/funct/rd from the datapath into its control inputs.
- Holds the NZCV condition-flag register, evaluates the 4-bit condition field and suppresses architectural writes of non-executing instructions.
- Keeps saturating executed/skipped instruction counters for debug readout.

Parameters:
CNT_W, 16, width of each performance counter

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-low reset
cond  in  4  instruction condition field
op  in  2  instruction class: 00 data-processing, 01 memory, 10 branch, 11 illegal
funct  in  6  instruction bits [25:20]
rd  in  4  destination register
alu_flags  in  4  ALU NZCV of the current instruction, bits [3:0] = N,Z,C,V
pc_src  out  1  1 = PC loads result
mem_to_reg  out  1  1 = write-back from memory
mem_write  out  1  data memory write enable
alu_control  out  4  ALU operation select
alu_src  out  1  1 = immediate operand B
reg_write  out  1  register-file write enable
reg_src  out  2  bit0 = ra1 from R15; bit1 = ra2 from rd
flags  out  4  registered NZCV
illegal_instr  out  1  current instruction undecodable
exec_count  out  CNT_W  executed-instruction counter
skip_count  out  CNT_W  condition-failed instruction counter

Behaviour:
- ALU encodings are fixed: ADD 0000, SUB 0001, AND 0010, ORR 0011.

Decode (combinational):
- op=00, data-processing:
  - alu_src=funct[5]; reg_src=00; mem_to_reg=0; mem_write=0.
  - cmd=funct[4:1]: 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR, 1010 CMP (SUB, no register write).
  - reg_write=1 except for CMP.
  - Any other cmd -> illegal.
- op=01, memory:
  - alu_src=~funct[5]; alu_control=ADD.
  - funct[0]=1 is LDR: mem_to_reg=1, reg_write=1, reg_src=00.
  - funct[0]=0 is STR: mem_write=1, reg_write=0, reg_src=10.
- op=10, branch: reg_src=01, alu_src=1, alu_control=ADD, pc_src=1, reg_write=0.
- op=11, or illegal cmd: illegal_instr=1. All write enables, pc_src and flag writes are 0; mux selects 0.
- pc_src is also 1 when reg_write decodes 1 and rd=4'hF.
- Flag-write enables:
  - fw_nz = (op=00) & funct[0].
  - fw_cv = fw_nz & cmd is ADD, SUB or CMP.
  - CMP always writes flags, regardless of funct[0].

Condition check, combinational, using the registered flags:
- EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V.
- HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V); AL 1; 1111 0.
- cond_ex=0 forces pc_src, reg_write, mem_write, fw_nz and fw_cv to 0. Mux selects are not forced.

Sequential:
- Flags register:
  - On the clock edge, if fw_nz & cond_ex, load flags[3:2] <= alu_flags[3:2].
  - If fw_cv & cond_ex, load flags[1:0] <= alu_flags[1:0].
  - An updated flag affects the next instruction only (1-cycle latency).
  - The current instruction never sees its own flags.
- Counters (per cycle, not illegal):
  - exec_count += 1 if cond_ex, else skip_count += 1.
  - Illegal instructions increment neither counter.
  - Both counters saturate at all-ones and never wrap.

Reset:
- rst=0 asynchronously clears flags, exec_count and skip_count.
- While rst=0: pc_src, reg_write and mem_write are forced to 0; other outputs follow decode.
- Reset asserted mid-operation takes effect immediately, with no wait for a clock edge.
- First edge after deassertion: normal behaviour with flags=0000. The EQ condition fails; NE executes.

Test Plan:
1. Reset, then cond=1110 op=00 funct=101000 rd=1 (ADD imm) -> alu_src=1, alu_control=0000, reg_write=1, pc_src=0, mem_write=0, flags stay 0000, exec_count=1 after the edge.
2. SUBS (funct=000101) with alu_flags=0110, then BEQ (cond=0000 op=10):
   - SUBS cycle: flags still 0000.
   - BEQ cycle: flags=0110, pc_src=1, reg_src=01.
   - Then BNE (cond=0001): pc_src=0, skip_count increments.
3. STR (op=01 funct=011000) -> mem_write=1, reg_src=10, alu_src=1, alu_control=0000, reg_write=0. Same encoding with cond=1111 -> mem_write=0, skip_count+1.
4. ADD, no S, with rd=4'hF -> pc_src=1, reg_write=1. op=11 -> illegal_instr=1, all enables 0, both counters unchanged.
5. CMP (funct=010101) with alu_flags=1001, then ANDS (funct=000001) with alu_flags=0100:
   - After CMP: flags=1001.
   - After ANDS: flags=0101 (C,V retained).
6. With CNT_W=2:
   - 5 executed instructions -> exec_count=3 (saturated).
   - Assert rst between edges -> all counters and flags read 0 immediately.

Source files
------------

// File: rtl/arm_control_unit.sv
// Control unit for the single-cycle ARM datapath: instruction decode, NZCV flag
// register, condition evaluation and saturating executed/skipped counters.
module arm_control_unit #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       cond,
    input  logic [1:0]       op,
    input  logic [5:0]       funct,
    input  logic [3:0]       rd,
    input  logic [3:0]       alu_flags,
    output logic             pc_src,
    output logic             mem_to_reg,
    output logic             mem_write,
    output logic [3:0]       alu_control,
    output logic             alu_src,
    output logic             reg_write,
    output logic [1:0]       reg_src,
    output logic [3:0]       flags,
    output logic             illegal_instr,
    output logic [CNT_W-1:0] exec_count,
    output logic [CNT_W-1:0] skip_count
);

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_ORR = 4'b0011;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [3:0]       flags_q, flags_d;
    logic [CNT_W-1:0] exec_count_q, exec_count_d;
    logic [CNT_W-1:0] skip_count_q, skip_count_d;

    logic [3:0] cmd;
    logic       dec_reg_write;
    logic       dec_mem_write;
    logic       dec_branch;
    logic       dec_pc_src;
    logic       dec_fw_nz;
    logic       dec_fw_cv;
    logic       dec_illegal;
    logic       dp_writes_flags;
    logic       dp_arith;
    logic       cond_ex;
    logic       fw_nz;
    logic       fw_cv;
    logic       flag_n, flag_z, flag_c, flag_v;

    assign cmd = funct[4:1];

    always_comb begin
        dec_reg_write   = 1'b0;
        dec_mem_write   = 1'b0;
        dec_branch      = 1'b0;
        dec_illegal     = 1'b0;
        dp_writes_flags = 1'b0;
        dp_arith        = 1'b0;
        mem_to_reg      = 1'b0;
        alu_src         = 1'b0;
        alu_control     = ALU_ADD;
        reg_src         = 2'b00;

        unique case (op)
            OP_DP: begin
                alu_src         = funct[5];
                dp_writes_flags = funct[0];
                case (cmd)
                    CMD_ADD: begin
                        alu_control   = ALU_ADD;
                        dec_reg_write = 1'b1;
                        dp_arith      = 1'b1;
                    end
                    CMD_SUB: begin
                        alu_control   = ALU_SUB;
                        dec_reg_write = 1'b1;
                        dp_arith      = 1'b1;
                    end
                    CMD_AND: begin
                        alu_control   = ALU_AND;
                        dec_reg_write = 1'b1;
                    end
                    CMD_ORR: begin
                        alu_control   = ALU_ORR;
                        dec_reg_write = 1'b1;
                    end
                    // CMP exists only for its flags, so it writes them even without S
                    CMD_CMP: begin
                        alu_control     = ALU_SUB;
                        dp_writes_flags = 1'b1;
                        dp_arith        = 1'b1;
                    end
                    default: begin
                        dec_illegal     = 1'b1;
                        alu_src         = 1'b0;
                        dp_writes_flags = 1'b0;
                    end
                endcase
            end
            OP_MEM: begin
                alu_src     = ~funct[5];
                alu_control = ALU_ADD;
                if (funct[0]) begin
                    mem_to_reg    = 1'b1;
                    dec_reg_write = 1'b1;
                end else begin
                    dec_mem_write = 1'b1;
                    reg_src       = 2'b10;
                end
            end
            OP_BR: begin
                reg_src     = 2'b01;
                alu_src     = 1'b1;
                alu_control = ALU_ADD;
                dec_branch  = 1'b1;
            end
            default: begin
                dec_illegal = 1'b1;
            end
        endcase
    end

    assign dec_fw_nz  = dp_writes_flags;
    assign dec_fw_cv  = dp_writes_flags & dp_arith;
    assign dec_pc_src = dec_branch | (dec_reg_write & (rd == 4'hF));

    assign flag_n = flags_q[3];
    assign flag_z = flags_q[2];
    assign flag_c = flags_q[1];
    assign flag_v = flags_q[0];

    // Evaluated on the registered flags: an instruction never sees its own result
    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            COND_EQ: cond_ex = flag_z;
            COND_NE: cond_ex = ~flag_z;
            COND_CS: cond_ex = flag_c;
            COND_CC: cond_ex = ~flag_c;
            COND_MI: cond_ex = flag_n;
            COND_PL: cond_ex = ~flag_n;
            COND_VS: cond_ex = flag_v;
            COND_VC: cond_ex = ~flag_v;
            COND_HI: cond_ex = flag_c & ~flag_z;
            COND_LS: cond_ex = ~flag_c | flag_z;
            COND_GE: cond_ex = (flag_n == flag_v);
            COND_LT: cond_ex = (flag_n != flag_v);
            COND_GT: cond_ex = ~flag_z & (flag_n == flag_v);
            COND_LE: cond_ex = flag_z | (flag_n != flag_v);
            COND_AL: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    assign fw_nz = dec_fw_nz & cond_ex;
    assign fw_cv = dec_fw_cv & cond_ex;

    // Architectural writes are held off combinationally for the whole reset window
    assign pc_src        = dec_pc_src    & cond_ex & rst;
    assign reg_write     = dec_reg_write & cond_ex & rst;
    assign mem_write     = dec_mem_write & cond_ex & rst;
    assign illegal_instr = dec_illegal;

    always_comb begin
        flags_d = flags_q;
        if (fw_nz) begin
            flags_d[3:2] = alu_flags[3:2];
        end
        if (fw_cv) begin
            flags_d[1:0] = alu_flags[1:0];
        end
    end

    always_comb begin
        exec_count_d = exec_count_q;
        skip_count_d = skip_count_q;
        if (!dec_illegal) begin
            if (cond_ex) begin
                if (exec_count_q != CNT_MAX) begin
                    exec_count_d = exec_count_q + CNT_ONE;
                end
            end else begin
                if (skip_count_q != CNT_MAX) begin
                    skip_count_d = skip_count_q + CNT_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flags_q      <= 4'b0000;
            exec_count_q <= '0;
            skip_count_q <= '0;
        end else begin
            flags_q      <= flags_d;
            exec_count_q <= exec_count_d;
            skip_count_q <= skip_count_d;
        end
    end

    assign flags      = flags_q;
    assign exec_count = exec_count_q;
    assign skip_count = skip_count_q;

endmodule

// File: tb/tb_arm_control_unit.sv
// Directed self-checking bench for arm_control_unit: decode, condition gating,
// flag latency, counters, and saturation/async reset on a 2-bit-counter instance.
module tb_arm_control_unit;

    logic        clk;
    logic        rst;
    logic        rst2;
    logic [3:0]  cond;
    logic [1:0]  op;
    logic [5:0]  funct;
    logic [3:0]  rd;
    logic [3:0]  alu_flags;

    logic        pc_src, mem_to_reg, mem_write, alu_src, reg_write, illegal_instr;
    logic [3:0]  alu_control, flags;
    logic [1:0]  reg_src;
    logic [15:0] exec_count, skip_count;

    logic        pc_src2, mem_to_reg2, mem_write2, alu_src2, reg_write2, illegal_instr2;
    logic [3:0]  alu_control2, flags2;
    logic [1:0]  reg_src2;
    logic [1:0]  exec_count2, skip_count2;

    int total;
    int bad;

    arm_control_unit #(.CNT_W(16)) u_dut (
        .clk           (clk),
        .rst           (rst),
        .cond          (cond),
        .op            (op),
        .funct         (funct),
        .rd            (rd),
        .alu_flags     (alu_flags),
        .pc_src        (pc_src),
        .mem_to_reg    (mem_to_reg),
        .mem_write     (mem_write),
        .alu_control   (alu_control),
        .alu_src       (alu_src),
        .reg_write     (reg_write),
        .reg_src       (reg_src),
        .flags         (flags),
        .illegal_instr (illegal_instr),
        .exec_count    (exec_count),
        .skip_count    (skip_count)
    );

    arm_control_unit #(.CNT_W(2)) u_dut_sat (
        .clk           (clk),
        .rst           (rst2),
        .cond          (cond),
        .op            (op),
        .funct         (funct),
        .rd            (rd),
        .alu_flags     (alu_flags),
        .pc_src        (pc_src2),
        .mem_to_reg    (mem_to_reg2),
        .mem_write     (mem_write2),
        .alu_control   (alu_control2),
        .alu_src       (alu_src2),
        .reg_write     (reg_write2),
        .reg_src       (reg_src2),
        .flags         (flags2),
        .illegal_instr (illegal_instr2),
        .exec_count    (exec_count2),
        .skip_count    (skip_count2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic set_instr(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f,
                             input logic [3:0] r, input logic [3:0] af);
        @(negedge clk);
        cond      = c;
        op        = o;
        funct     = f;
        rd        = r;
        alu_flags = af;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [1:0] sat_exp [5];

    initial begin
        total = 0;
        bad   = 0;
        sat_exp[0] = 2'd1;
        sat_exp[1] = 2'd2;
        sat_exp[2] = 2'd3;
        sat_exp[3] = 2'd3;
        sat_exp[4] = 2'd3;

        rst       = 1'b0;
        rst2      = 1'b0;
        cond      = 4'hE;
        op        = 2'b11;
        funct     = 6'b000000;
        rd        = 4'h0;
        alu_flags = 4'h0;
        #3;
        chk("rst_flags", 32'(flags), 32'h0);
        chk("rst_exec", 32'(exec_count), 32'h0);
        chk("rst_skip", 32'(skip_count), 32'h0);
        chk("rst_illegal", 32'(illegal_instr), 32'h1);
        @(negedge clk);
        rst = 1'b1;

        // ADD immediate
        set_instr(4'hE, 2'b00, 6'b101000, 4'h1, 4'h0);
        chk("add_alu_src", 32'(alu_src), 32'h1);
        chk("add_alu_ctl", 32'(alu_control), 32'h0);
        chk("add_reg_write", 32'(reg_write), 32'h1);
        chk("add_pc_src", 32'(pc_src), 32'h0);
        chk("add_mem_write", 32'(mem_write), 32'h0);
        tick();
        chk("add_flags", 32'(flags), 32'h0);
        chk("add_exec", 32'(exec_count), 32'd1);

        // SUBS then BEQ: flags visible one instruction later
        set_instr(4'hE, 2'b00, 6'b000101, 4'h2, 4'b0110);
        chk("subs_alu_ctl", 32'(alu_control), 32'h1);
        chk("subs_flags_pre", 32'(flags), 32'h0);
        tick();
        set_instr(4'h0, 2'b10, 6'b000000, 4'h0, 4'h0);
        chk("beq_flags", 32'(flags), 32'b0110);
        chk("beq_pc_src", 32'(pc_src), 32'h1);
        chk("beq_reg_src", 32'(reg_src), 32'b01);
        tick();
        chk("beq_exec", 32'(exec_count), 32'd3);
        set_instr(4'h1, 2'b10, 6'b000000, 4'h0, 4'h0);
        chk("bne_pc_src", 32'(pc_src), 32'h0);
        chk("bne_reg_src", 32'(reg_src), 32'b01);
        tick();
        chk("bne_skip", 32'(skip_count), 32'd1);
        chk("bne_exec", 32'(exec_count), 32'd3);

        // STR, executing and with cond=1111
        set_instr(4'hE, 2'b01, 6'b011000, 4'h3, 4'h0);
        chk("str_mem_write", 32'(mem_write), 32'h1);
        chk("str_reg_src", 32'(reg_src), 32'b10);
        chk("str_alu_src", 32'(alu_src), 32'h1);
        chk("str_alu_ctl", 32'(alu_control), 32'h0);
        chk("str_reg_write", 32'(reg_write), 32'h0);
        tick();
        set_instr(4'hF, 2'b01, 6'b011000, 4'h3, 4'h0);
        chk("strnv_mem_write", 32'(mem_write), 32'h0);
        chk("strnv_reg_src", 32'(reg_src), 32'b10);
        tick();
        chk("strnv_skip", 32'(skip_count), 32'd2);
        chk("strnv_exec", 32'(exec_count), 32'd4);

        // ADD to R15, then op=11
        set_instr(4'hE, 2'b00, 6'b001000, 4'hF, 4'h0);
        chk("addpc_pc_src", 32'(pc_src), 32'h1);
        chk("addpc_reg_write", 32'(reg_write), 32'h1);
        tick();
        set_instr(4'hE, 2'b11, 6'b101001, 4'hF, 4'hF);
        chk("ill_flag", 32'(illegal_instr), 32'h1);
        chk("ill_enables", 32'({pc_src, reg_write, mem_write, mem_to_reg}), 32'h0);
        chk("ill_selects", 32'({alu_src, reg_src}), 32'h0);
        tick();
        chk("ill_exec", 32'(exec_count), 32'd5);
        chk("ill_skip", 32'(skip_count), 32'd2);
        chk("ill_flags", 32'(flags), 32'b0110);

        // CMP then ANDS: ANDS leaves C,V
        set_instr(4'hE, 2'b00, 6'b010101, 4'h0, 4'b1001);
        chk("cmp_reg_write", 32'(reg_write), 32'h0);
        chk("cmp_alu_ctl", 32'(alu_control), 32'h1);
        tick();
        chk("cmp_flags", 32'(flags), 32'b1001);
        set_instr(4'hE, 2'b00, 6'b000001, 4'h4, 4'b0100);
        chk("ands_alu_ctl", 32'(alu_control), 32'h2);
        tick();
        chk("ands_flags", 32'(flags), 32'b0101);

        // flags=0101: LT executes, GT fails
        set_instr(4'hB, 2'b10, 6'b000000, 4'h0, 4'h0);
        chk("blt_pc_src", 32'(pc_src), 32'h1);
        tick();
        set_instr(4'hC, 2'b10, 6'b000000, 4'h0, 4'h0);
        chk("bgt_pc_src", 32'(pc_src), 32'h0);
        tick();
        set_instr(4'hE, 2'b00, 6'b000010, 4'h1, 4'hF);
        chk("badcmd_illegal", 32'(illegal_instr), 32'h1);
        chk("badcmd_reg_write", 32'(reg_write), 32'h0);
        tick();
        chk("badcmd_exec", 32'(exec_count), 32'd8);
        chk("badcmd_skip", 32'(skip_count), 32'd3);
        chk("badcmd_flags", 32'(flags), 32'b0101);

        // LDR
        set_instr(4'hE, 2'b01, 6'b011001, 4'h4, 4'h0);
        chk("ldr_mem_to_reg", 32'(mem_to_reg), 32'h1);
        chk("ldr_reg_write", 32'(reg_write), 32'h1);
        chk("ldr_reg_src", 32'(reg_src), 32'b00);
        chk("ldr_mem_write", 32'(mem_write), 32'h0);
        tick();
        chk("ldr_exec", 32'(exec_count), 32'd9);

        // 2-bit counters saturate; then async reset mid-cycle
        set_instr(4'hE, 2'b11, 6'b000000, 4'h0, 4'h0);
        rst2 = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            if (i == 4) begin
                set_instr(4'hE, 2'b00, 6'b101001, 4'h1, 4'b1010);
            end else begin
                set_instr(4'hE, 2'b00, 6'b101000, 4'h1, 4'h0);
            end
            tick();
            chk("sat_exec", 32'(exec_count2), 32'(sat_exp[i]));
        end
        chk("sat_skip", 32'(skip_count2), 32'h0);
        chk("sat_flags", 32'(flags2), 32'b1010);
        chk("main_exec", 32'(exec_count), 32'd14);
        chk("main_flags", 32'(flags), 32'b1010);

        #2;
        rst  = 1'b0;
        rst2 = 1'b0;
        #1;
        chk("arst_flags", 32'(flags), 32'h0);
        chk("arst_exec", 32'(exec_count), 32'h0);
        chk("arst_skip", 32'(skip_count), 32'h0);
        chk("arst_flags2", 32'(flags2), 32'h0);
        chk("arst_exec2", 32'(exec_count2), 32'h0);
        chk("arst_skip2", 32'(skip_count2), 32'h0);
        chk("arst_reg_write", 32'(reg_write), 32'h0);
        chk("arst_pc_src", 32'(pc_src), 32'h0);
        chk("arst_alu_src", 32'(alu_src), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
